axil_stream_bridge: RTL

- AXI4-Lite slave front-end that converts the five AXI-Lite channels into the five valid/ready streams consumed by the generated map blocks:
  - read address sRA, read data sR;
  - write address sWA, write data sW;
  - write response sB, a null stream.
- Sits directly upstream of a map block such as the array-backed write/read map. It converts byte addresses to word indices.
- Rejects unaligned, out-of-range or partial-strobe accesses locally with SLVERR, so the map never sees them.
- Keeps all responses in request order.

---
 rtl/axil_stream_bridge_pkg.sv | 21 ++
 rtl/axil_stream_bridge_tag.sv | 73 +++++++
 rtl/axil_stream_bridge.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/axil_stream_bridge_pkg.sv
// Shared definitions for the AXI4-Lite to valid/ready stream bridge.
//   RESP_*      : AXI response codes driven on bresp/rresp
//   tag_e       : per-request tag held in the ordering FIFOs
//   stream_hs_t : stream convention, payload qualified by valid and
//                 transferred on a cycle where valid && ready
package axil_stream_bridge_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    TAG_OKAY = 1'b0,
    TAG_ERR  = 1'b1
  } tag_e;

  typedef struct packed {
    logic valid;
    logic ready;
  } stream_hs_t;

endpackage

// File: rtl/axil_stream_bridge_tag.sv
// tag_fifo: 1-bit ordering FIFO recording whether each accepted request
// was forwarded (TAG_OKAY) or rejected locally (TAG_ERR).
//   clk, rst        : clock, synchronous active-high reset
//   push, push_tag  : enqueue a tag (ignored when full)
//   pop             : dequeue the head (ignored when empty)
//   full, empty     : occupancy flags
//   head            : tag at the head of the FIFO
module tag_fifo
  import axil_stream_bridge_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  tag_e push_tag,
  input  logic pop,
  output logic full,
  output logic empty,
  output tag_e head
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = tag_e'(mem_q[rd_ptr_q]);

  // Push is gated on the pre-pop occupancy, so a pop never makes room
  // for a push in the same cycle.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_tag;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/axil_stream_bridge.sv
// axil_stream_bridge: AXI4-Lite slave front-end feeding a word-addressed
// map block over valid/ready streams. Unaligned, out-of-range and
// partial-strobe accesses are answered locally with SLVERR; responses
// stay in request order via one tag FIFO per direction.
//   s_aw*/s_w*/s_b*/s_ar*/s_r* : AXI4-Lite slave channels
//   sWA/sW  (+valid/ready)     : write word index / write data to map
//   sB_valid/sB_ready          : null-stream write acknowledge from map
//   sRA     (+valid/ready)     : read word index to map
//   sR      (+valid/ready)     : read data from map
module axil_stream_bridge
  import axil_stream_bridge_pkg::*;
#(
  parameter int unsigned AXI_ADDR_N = 16,
  parameter int unsigned ADDR_N     = 10,
  parameter int unsigned DATA_N     = 32,
  parameter int unsigned DEPTH      = 1000,
  parameter int unsigned MAX_OUT    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AXI_ADDR_N-1:0] s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [DATA_N-1:0]     s_wdata,
  input  logic [3:0]            s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [AXI_ADDR_N-1:0] s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [DATA_N-1:0]     s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [ADDR_N-1:0]     sWA,
  output logic                  sWA_valid,
  input  logic                  sWA_ready,
  output logic [DATA_N-1:0]     sW,
  output logic                  sW_valid,
  input  logic                  sW_ready,
  input  logic                  sB_valid,
  output logic                  sB_ready,
  output logic [ADDR_N-1:0]     sRA,
  output logic                  sRA_valid,
  input  logic                  sRA_ready,
  input  logic [DATA_N-1:0]     sR,
  input  logic                  sR_valid,
  output logic                  sR_ready
);

  localparam logic [AXI_ADDR_N-1:0] DEPTH_W = AXI_ADDR_N'(DEPTH);

  logic                  aw_full_q, aw_full_d;
  logic [AXI_ADDR_N-1:0] aw_addr_q, aw_addr_d;
  logic                  w_full_q, w_full_d;
  logic [DATA_N-1:0]     w_data_q, w_data_d;
  logic [3:0]            w_strb_q, w_strb_d;
  logic                  ar_full_q, ar_full_d;
  logic [AXI_ADDR_N-1:0] ar_addr_q, ar_addr_d;
  logic                  wa_done_q, wa_done_d;
  logic                  w_done_q, w_done_d;

  logic [AXI_ADDR_N-1:0] aw_word, ar_word;
  logic wr_err, rd_err, wr_issue, rd_issue, wr_done, rd_done;
  logic wtag_full, wtag_empty, rtag_full, rtag_empty;
  tag_e wtag_head, rtag_head;
  logic wtag_pop, rtag_pop;

  assign aw_word = {2'b00, aw_addr_q[AXI_ADDR_N-1:2]};
  assign ar_word = {2'b00, ar_addr_q[AXI_ADDR_N-1:2]};
  assign wr_err  = (aw_addr_q[1:0] != 2'b00) || (aw_word >= DEPTH_W) || (w_strb_q != 4'hF);
  assign rd_err  = (ar_addr_q[1:0] != 2'b00) || (ar_word >= DEPTH_W);

  assign s_awready = !rst && !aw_full_q;
  assign s_wready  = !rst && !w_full_q;
  assign s_arready = !rst && !ar_full_q;

  assign sWA = aw_addr_q[ADDR_N+1:2];
  assign sW  = w_data_q;
  assign sRA = ar_addr_q[ADDR_N+1:2];

  assign wr_issue  = aw_full_q && w_full_q && !wtag_full;
  assign rd_issue  = ar_full_q && !rtag_full;
  assign sWA_valid = !rst && wr_issue && !wr_err && !wa_done_q;
  assign sW_valid  = !rst && wr_issue && !wr_err && !w_done_q;
  assign sRA_valid = !rst && rd_issue && !rd_err;

  // A forwarded write retires once both AW and W streams have handshaken,
  // in either order; a rejected one retires as soon as it is issued.
  assign wr_done = wr_issue &&
                   (wr_err || ((wa_done_q || (sWA_valid && sWA_ready)) &&
                               (w_done_q  || (sW_valid  && sW_ready))));
  assign rd_done = rd_issue && (rd_err || (sRA_valid && sRA_ready));

  always_comb begin
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    ar_full_d = ar_full_q;
    ar_addr_d = ar_addr_q;
    wa_done_d = wa_done_q;
    w_done_d  = w_done_q;

    if (s_awvalid && s_awready) begin
      aw_full_d = 1'b1;
      aw_addr_d = s_awaddr;
    end
    if (s_wvalid && s_wready) begin
      w_full_d = 1'b1;
      w_data_d = s_wdata;
      w_strb_d = s_wstrb;
    end
    if (s_arvalid && s_arready) begin
      ar_full_d = 1'b1;
      ar_addr_d = s_araddr;
    end

    if (wr_done) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      wa_done_d = 1'b0;
      w_done_d  = 1'b0;
    end else begin
      wa_done_d = wa_done_q || (sWA_valid && sWA_ready);
      w_done_d  = w_done_q  || (sW_valid  && sW_ready);
    end

    if (rd_done) begin
      ar_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      ar_full_q <= 1'b0;
      ar_addr_q <= '0;
      wa_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      ar_full_q <= ar_full_d;
      ar_addr_q <= ar_addr_d;
      wa_done_q <= wa_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Response channels: head tag selects local SLVERR or map pass-through.
  always_comb begin
    s_bvalid = 1'b0;
    s_bresp  = RESP_OKAY;
    sB_ready = 1'b0;
    if (!rst && !wtag_empty) begin
      if (wtag_head == TAG_ERR) begin
        s_bvalid = 1'b1;
        s_bresp  = RESP_SLVERR;
      end else begin
        s_bvalid = sB_valid;
        sB_ready = s_bready;
      end
    end
  end

  always_comb begin
    s_rvalid = 1'b0;
    s_rresp  = RESP_OKAY;
    s_rdata  = '0;
    sR_ready = 1'b0;
    if (!rst && !rtag_empty) begin
      if (rtag_head == TAG_ERR) begin
        s_rvalid = 1'b1;
        s_rresp  = RESP_SLVERR;
      end else begin
        s_rvalid = sR_valid;
        s_rdata  = sR;
        sR_ready = s_rready;
      end
    end
  end

  assign wtag_pop = s_bvalid && s_bready;
  assign rtag_pop = s_rvalid && s_rready;

  tag_fifo #(.DEPTH(MAX_OUT)) u_wtag (
    .clk      (clk),
    .rst      (rst),
    .push     (wr_done),
    .push_tag (wr_err ? TAG_ERR : TAG_OKAY),
    .pop      (wtag_pop),
    .full     (wtag_full),
    .empty    (wtag_empty),
    .head     (wtag_head)
  );

  tag_fifo #(.DEPTH(MAX_OUT)) u_rtag (
    .clk      (clk),
    .rst      (rst),
    .push     (rd_done),
    .push_tag (rd_err ? TAG_ERR : TAG_OKAY),
    .pop      (rtag_pop),
    .full     (rtag_full),
    .empty    (rtag_empty),
    .head     (rtag_head)
  );

endmodule
